// File: rtl/nonce_select.sv
// Scans NUM_NONCES hash words on the shared memory port, keeps the smallest one,
// then writes the winning hash and nonce back as a two-word result record.
module nonce_select #(
   parameter int NUM_NONCES = 16,
   parameter int NONCE_W    = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [15:0]        hash_addr,
   input  logic [15:0]        result_addr,
   input  logic [31:0]        target,
   output logic               done,
   output logic               found,
   output logic [NONCE_W-1:0] best_nonce,
   output logic [31:0]        best_hash,
   output logic               mem_clk,
   output logic               mem_we,
   output logic [15:0]        mem_addr,
   output logic [31:0]        mem_write_data,
   input  logic [31:0]        mem_read_data
);

   // state      | meaning
   // S_IDLE     | waiting for start
   // S_READ     | issuing hash addresses and capturing returned words
   // S_WR_HASH  | writing best hash to result_addr
   // S_WR_NONCE | writing best nonce to result_addr+1, latching found
   // S_DONE     | pulsing done, back to idle
   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WR_HASH, S_WR_NONCE, S_DONE
   } state_t;

   localparam int CNT_W = $clog2(NUM_NONCES + 1);
   localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(NUM_NONCES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NONCES - 1);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_rd_cnt, w_rd_cnt_nxt;
   logic [CNT_W-1:0]   r_cap_cnt, w_cap_cnt_nxt;
   logic               r_warm, w_warm_nxt;
   logic               r_done, w_done_nxt;
   logic               r_found, w_found_nxt;
   logic [NONCE_W-1:0] r_best_nonce, w_best_nonce_nxt;
   logic [31:0]        r_best_hash, w_best_hash_nxt;
   logic               r_mem_we, w_mem_we_nxt;
   logic [15:0]        r_mem_addr, w_mem_addr_nxt;
   logic [31:0]        r_mem_wdata, w_mem_wdata_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_rd_cnt     <= '0;
         r_cap_cnt    <= '0;
         r_warm       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_best_nonce <= '0;
         r_best_hash  <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_rd_cnt     <= w_rd_cnt_nxt;
         r_cap_cnt    <= w_cap_cnt_nxt;
         r_warm       <= w_warm_nxt;
         r_done       <= w_done_nxt;
         r_found      <= w_found_nxt;
         r_best_nonce <= w_best_nonce_nxt;
         r_best_hash  <= w_best_hash_nxt;
         r_mem_we     <= w_mem_we_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_rd_cnt_nxt     = r_rd_cnt;
      w_cap_cnt_nxt    = r_cap_cnt;
      w_warm_nxt       = r_warm;
      w_done_nxt       = 1'b0;
      w_found_nxt      = r_found;
      w_best_nonce_nxt = r_best_nonce;
      w_best_hash_nxt  = r_best_hash;
      w_mem_we_nxt     = r_mem_we;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_mem_we_nxt   = 1'b0;
               w_mem_addr_nxt = hash_addr;
               w_rd_cnt_nxt   = CNT_W'(1);
               w_cap_cnt_nxt  = '0;
               w_warm_nxt     = 1'b0;
               w_state_nxt    = S_READ;
            end
         end
         S_READ: begin
            w_mem_we_nxt = 1'b0;
            if (r_rd_cnt < CNT_N) begin
               w_mem_addr_nxt = hash_addr + 16'(r_rd_cnt);
               w_rd_cnt_nxt   = r_rd_cnt + 1'b1;
            end
            // Read data lags the address by two edges; the first READ edge has nothing to capture.
            if (!r_warm) begin
               w_warm_nxt = 1'b1;
            end else begin
               if ((r_cap_cnt == '0) || (mem_read_data < r_best_hash)) begin
                  w_best_hash_nxt  = mem_read_data;
                  w_best_nonce_nxt = NONCE_W'(r_cap_cnt);
               end
               w_cap_cnt_nxt = r_cap_cnt + 1'b1;
               if (r_cap_cnt == CNT_LAST)
                  w_state_nxt = S_WR_HASH;
            end
         end
         S_WR_HASH: begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = result_addr;
            w_mem_wdata_nxt = r_best_hash;
            w_state_nxt     = S_WR_NONCE;
         end
         S_WR_NONCE: begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = result_addr + 16'd1;
            w_mem_wdata_nxt = 32'(r_best_nonce);
            w_found_nxt     = (r_best_hash < target);
            w_state_nxt     = S_DONE;
         end
         S_DONE: begin
            w_mem_we_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign mem_clk        = clk;
   assign done           = r_done;
   assign found          = r_found;
   assign best_nonce     = r_best_nonce;
   assign best_hash      = r_best_hash;
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_write_data = r_mem_wdata;

endmodule

// File: doc/nonce_select.md
Name: nonce_select

Overview:
- Consumer stage directly downstream of the bitcoin hash engine.
- After the engine has written one final H0 word per nonce to consecutive memory words starting at hash_addr, this block scans those NUM_NONCES words over the same shared memory port.
- It selects the smallest hash as an unsigned value and compares it against a target.
- It writes the winning hash and nonce back to memory and reports both on ports.

Parameters:
- NUM_NONCES, 16, number of consecutive hash words to scan (2..64).
- NONCE_W, 6, width of the nonce index outputs.

Ports:
- clk  input  1  system clock; also drives mem_clk.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- hash_addr  input  16  base address of hash word 0 (nonce 0).
- result_addr  input  16  base address of the 2-word result record.
- target  input  32  difficulty threshold, unsigned.
- done  output  1  one-cycle pulse when the scan and write-back are complete.
- found  output  1  best_hash < target; valid from done, held until the next start.
- best_nonce  output  NONCE_W  index of the smallest hash; held until the next start.
- best_hash  output  32  smallest hash value; held until the next start.
- mem_clk  output  1  equals clk.
- mem_we  output  1  memory write enable.
- mem_addr  output  16  memory address.
- mem_write_data  output  32  memory write data.
- mem_read_data  input  32  memory read data.

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - done, found, mem_we = 0.
  - best_nonce, best_hash, mem_addr, mem_write_data = 0.
  - Internal counters = 0.
- Reset mid-operation: the block returns to IDLE immediately with mem_we = 0, and no partial result write completes.
- Memory timing: a read address driven at edge E returns data sampled at edge E+2. The block drives exactly one address per cycle, pipelined.
- States: IDLE, READ, WR_HASH, WR_NONCE, DONE.
- Timeline (edge 0 = the edge at which start = 1 is sampled in IDLE):
  - Edge 0: mem_we <= 0, mem_addr <= hash_addr, rd_cnt <= 1, cap_cnt <= 0, go to READ.
  - READ, issue side: while rd_cnt < NUM_NONCES, mem_addr <= hash_addr + rd_cnt and rd_cnt increments. Once all addresses are issued, mem_addr holds.
  - READ, capture side: at edges 2 .. NUM_NONCES+1, word cap_cnt is captured from mem_read_data and cap_cnt increments.
  - Capture of index 0: loads best_hash and best_nonce unconditionally.
  - Capture of index i > 0: replaces best only if mem_read_data < best_hash (unsigned, strict). On a tie the lower index is kept.
  - After the capture of index NUM_NONCES-1, go to WR_HASH.
  - WR_HASH (edge NUM_NONCES+2): mem_we <= 1, mem_addr <= result_addr, mem_write_data <= best_hash, including any update made at the final capture edge.
  - WR_NONCE (edge NUM_NONCES+3): mem_we <= 1, mem_addr <= result_addr + 1, mem_write_data <= zero-extended best_nonce. found <= (best_hash < target).
  - DONE (edge NUM_NONCES+4): mem_we <= 0, done <= 1.
  - Next edge: done <= 0, go to IDLE.
- Latency: start sampled at edge 0 → done high after edge NUM_NONCES+4 (20 cycles at default). done is high for exactly 1 cycle.
- start while not in IDLE: ignored, with no restart and no effect on outputs. start held high in IDLE after done: a new scan begins at the next edge.
- found when best_hash == target: 0 (strict compare). target = 0: found is always 0. target = FFFFFFFF: found = 1 unless all hashes are FFFFFFFF.
- Address arithmetic: 16-bit, wraps modulo 2^16. For example, hash_addr = FFFE with 4 nonces reads FFFE, FFFF, 0000, 0001.
- Memory usage: the block issues no memory writes other than the two result writes. mem_we is never high in READ.

Test Plan:
- Distinct hashes: words 0..15 = 32'h1000_0000 + 16·i, except word 9 = 32'h0000_0042; target = 32'h0000_1000 → best_nonce = 9, best_hash = 00000042, found = 1. Memory shows [result_addr] = 00000042 and [result_addr+1] = 00000009. done high exactly once, 20 cycles after start.
- Ties and last-index minimum: all words = 32'h00000005 → best_nonce = 0. Then word 15 = 32'h00000004 → best_nonce = 15, proving the final capture reaches WR_HASH.
- Target boundary: min hash = 32'h0000_1000 with target = 32'h0000_1000 → found = 0. Same hashes with target = 32'h0000_1001 → found = 1.
- Address wrap and parameter: NUM_NONCES = 4, hash_addr = 16'hFFFE → addresses FFFE, FFFF, 0000, 0001 are read in consecutive cycles. done arrives 8 cycles after start.
- Reset mid-scan: deassert reset_n at cycle 7 of a scan → all outputs 0 immediately and no write occurs. A following start completes a normal scan.
- Start while busy: pulse start at cycles 3 and 10 of a scan → a single done pulse, results identical to the undisturbed run, and the next scan only starts from IDLE.
